// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule types, widths and round constants
package aes_pkg;

  localparam int AES_BYTES     = 16;
  localparam int AES128_ROUNDS = 10;
  localparam int ROUND_W       = 4;
  localparam int IDX_W         = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AES_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  // Round constant applied when producing round key rnd (1..10).
  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_stream_ctrl_if.sv
// rtl/aes_key_stream_ctrl_if.sv - key load and round-key byte stream bundle
interface aes_key_stream_ctrl_if;
  import aes_pkg::*;

  logic [127:0]         key_in;
  logic                 key_valid;
  logic                 key_ready;
  logic                 abort;
  logic [7:0]           kb_data;
  logic                 kb_valid;
  logic                 kb_ready;
  logic [ROUND_W-1:0]   kb_round;
  logic [IDX_W-1:0]     kb_idx;
  logic                 kb_last;
  logic                 busy;

  modport master (
    input  key_in, key_valid, abort, kb_ready,
    output key_ready, kb_data, kb_valid, kb_round, kb_idx, kb_last, busy
  );

  modport slave (
    output key_in, key_valid, abort, kb_ready,
    input  key_ready, kb_data, kb_valid, kb_round, kb_idx, kb_last, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box (GF(2^8) inverse followed by affine map)
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1b);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
    return (a << k) | (a >> (8 - k));
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 via an addition chain; maps 0 to 0 as the S-box requires.
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    dout = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_stream_ctrl.sv
// rtl/aes_key_stream_ctrl.sv - flow-controlled byte-serial AES-128 round-key streamer
module aes_key_stream_ctrl
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES128_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_key_stream_ctrl_if.master bus
);

  state_e               state_q, state_d;
  logic [127:0]         rk_q, rk_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [31:0]          w0, w1, w2, w3;
  logic [31:0]          rot_w, sub_w, t_w;
  logic [31:0]          n0, n1, n2, n3;
  logic                 xfer;
  logic                 final_round;

  assign w0    = rk_q[127:96];
  assign w1    = rk_q[95:64];
  assign w2    = rk_q[63:32];
  assign w3    = rk_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w[8*b +: 8]),
      .dout (sub_w[8*b +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon(round_q + 4'd1), 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign final_round = (round_q == ROUND_W'(NROUNDS));
  assign xfer        = (state_q == ST_STREAM) && bus.kb_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          rk_d    = bus.key_in;
          round_d = '0;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 4'd1;
          end else if (final_round) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EXPAND;
          end
        end
        // A byte accepted alongside abort still counts; only the state is forced.
        if (bus.abort) state_d = ST_IDLE;
      end
      ST_EXPAND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          rk_d    = {n0, n1, n2, n3};
          round_d = round_q + 4'd1;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      round_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      idx_q   <= idx_d;
    end
  end

  // Byte 0 is the MSB byte, so the bit offset is 8*(15-idx) = {~idx, 3'b000}.
  assign bus.kb_data   = rk_q[{~idx_q, 3'b000} +: 8];
  assign bus.kb_valid  = (state_q == ST_STREAM);
  assign bus.kb_round  = round_q;
  assign bus.kb_idx    = idx_q;
  assign bus.kb_last   = (state_q == ST_STREAM) && (idx_q == LAST_IDX) && final_round;
  assign bus.key_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_key_stream_ctrl.sv
// tb/tb_aes_key_stream_ctrl.sv - scoreboard bench for the AES-128 round-key streamer
module tb_aes_key_stream_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] rnd;
    logic [3:0] idx;
    logic       last;
    logic       chk;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  sb_t  q[$];

  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] zero_rk1  = 128'h62636363626363636263636362636363;
  logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_stream_ctrl_if bus ();

  aes_key_stream_ctrl #(.NROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bytes of the first n_bytes of a stream; zero key only has known data for rounds 0, 1, 10.
  task automatic push_stream(input bit zero_key, input int n_bytes);
    sb_t          e;
    logic [127:0] w;
    for (int b = 0; b < n_bytes; b++) begin
      int r = b / 16;
      int i = b % 16;
      if (!zero_key) begin
        w     = fips_rk[r];
        e.chk = 1'b1;
      end else begin
        w     = (r == 1) ? zero_rk1 : (r == 10) ? zero_rk10 : 128'h0;
        e.chk = (r == 0) || (r == 1) || (r == 10);
      end
      e.data = w[8*(15-i) +: 8];
      e.rnd  = 4'(r);
      e.idx  = 4'(i);
      e.last = (r == 10) && (i == 15);
      q.push_back(e);
    end
  endtask

  sb_t         mon_e;
  logic        stall_pend = 1'b0;
  logic [16:0] stall_prev = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_pend)
        check("stall_hold", {15'd0, bus.kb_valid, bus.kb_data, bus.kb_round, bus.kb_idx},
              {15'd0, 1'b1, stall_prev[15:0]});
      if (bus.kb_valid && bus.kb_ready) begin
        if (q.size() == 0) begin
          check("unexpected_byte", {bus.kb_round, bus.kb_idx, bus.kb_data}, 32'hffff_ffff);
        end else begin
          mon_e = q.pop_front();
          check("kb_byte",
                {15'd0, (mon_e.chk ? bus.kb_data : 8'h00), bus.kb_round, bus.kb_idx, bus.kb_last},
                {15'd0, (mon_e.chk ? mon_e.data : 8'h00), mon_e.rnd, mon_e.idx, mon_e.last});
        end
      end
      stall_pend <= bus.kb_valid && !bus.kb_ready && !bus.abort;
      stall_prev <= {1'b1, bus.kb_data, bus.kb_round, bus.kb_idx};
    end else begin
      stall_pend <= 1'b0;
    end
  end

  task automatic send_key(input logic [127:0] k);
    int cyc = 0;
    while (!bus.key_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("key_ready_wait", {31'd0, bus.key_ready}, 32'd1);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    check("first_byte", {15'd0, bus.kb_valid, bus.kb_data, bus.kb_round, bus.kb_idx},
          {15'd0, 1'b1, k[127:120], 4'd0, 4'd0});
  endtask

  task automatic drain(input bit rnd_ready);
    int cyc = 0;
    while ((q.size() != 0 || bus.busy) && cyc < 4000) begin
      @(posedge clk); #1;
      if (rnd_ready) bus.kb_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    bus.kb_ready = 1'b1;
    check("sb_empty", q.size(), 32'd0);
    check("idle_after_drain", {30'd0, bus.busy, bus.key_ready}, 32'd1);
    q.delete();
  endtask

  initial begin
    int cyc;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.kb_ready  = 1'b1;
    #1;
    check("reset_outputs",
          {bus.kb_valid, bus.key_ready, bus.busy, bus.kb_last, bus.kb_data, bus.kb_round, bus.kb_idx, 12'd0},
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 12'd0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full FIPS-197 stream with no back-pressure, timed end to end.
    push_stream(1'b0, 176);
    send_key(fips_key);
    check("busy_no_ready", {30'd0, bus.busy, bus.key_ready}, 32'd2);
    cyc = 0;
    while (bus.busy && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_cycles", cyc, 32'd186);
    drain(1'b0);

    // Same key under random back-pressure.
    push_stream(1'b0, 176);
    bus.kb_ready = 1'($urandom_range(0, 1));
    send_key(fips_key);
    drain(1'b1);

    // key_valid held through a stream: second key taken the cycle after the last byte.
    push_stream(1'b0, 176);
    bus.key_in    = fips_key;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_in = 128'h0;
    push_stream(1'b1, 176);
    repeat (60) @(posedge clk);
    #1;
    check("held_key_ready", {30'd0, bus.key_ready, bus.busy}, 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("held_gap_idle", {30'd0, bus.key_ready, bus.kb_valid}, 32'd2);
    @(posedge clk); #1;
    check("held_second_start", {14'd0, bus.kb_valid, bus.busy, bus.kb_data, bus.kb_round, bus.kb_idx},
          {14'd0, 1'b1, 1'b1, 8'h00, 4'd0, 4'd0});
    bus.key_valid = 1'b0;
    drain(1'b0);

    // Abort while round 3 byte 7 is handshaken.
    push_stream(1'b0, 3*16 + 8);
    send_key(fips_key);
    cyc = 0;
    while (!(bus.kb_valid && bus.kb_round == 4'd3 && bus.kb_idx == 4'd7) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_idle", {29'd0, bus.kb_valid, bus.key_ready, bus.busy}, 32'd2);
    check("abort_sb_empty", q.size(), 32'd0);
    push_stream(1'b1, 176);
    send_key(128'h0);
    drain(1'b0);

    // Asynchronous reset during the round-5 expansion bubble.
    push_stream(1'b0, 6*16);
    send_key(fips_key);
    cyc = 0;
    while (!(bus.busy && !bus.kb_valid && bus.kb_round == 4'd5) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("expand_r5_seen", {31'd0, (bus.busy && !bus.kb_valid)}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {bus.kb_valid, bus.key_ready, bus.busy, bus.kb_last, bus.kb_data, bus.kb_round, bus.kb_idx, 12'd0},
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 12'd0});
    check("rst_sb_empty", q.size(), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_stream(1'b1, 176);
    send_key(128'h0);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
